// File: rtl/haze_generate_core.sv
// -----------------------------------------------------------------------------
// haze_generate_core
//
// Haze (low-frequency scatter background) estimator for the laser acquisition
// path. Each valid 32-bit laser sample is conditioned to DATA_WIDTH bits and
// pushed into a 2**AVG_SHIFT deep history buffer. A running sum of the window
// is maintained, and the boxcar average (sum >> AVG_SHIFT) is emitted once per
// accepted sample after the window has filled.
//
// Parameters
//   DATA_WIDTH  width of conditioned samples and of haze_data_o (<= 32)
//   AVG_SHIFT   log2 of the window length WIN (1..6)
//
// Optional feature macro
//   HAZE_SAT_EN  defined  : samples above 2**DATA_WIDTH-1 clamp to all ones
//                undefined: samples are truncated to their low DATA_WIDTH bits
//
// Ports
//   clk_i         in   1           system clock, rising edge
//   rst_i         in   1           asynchronous active-high reset
//   laser_vld_i   in   1           sample strobe, one sample per high cycle
//   laser_data_i  in   32          unsigned laser sample
//   haze_vld_o    out  1           one-cycle pulse, haze_data_o updated
//   haze_data_o   out  DATA_WIDTH  moving-average haze value, held between pulses
//
// Timing: sample accepted at edge k -> haze_vld_o high after edge k+1.
// -----------------------------------------------------------------------------
module haze_generate_core #(
  parameter int DATA_WIDTH = 16,
  parameter int AVG_SHIFT  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  laser_vld_i,
  input  logic [31:0]           laser_data_i,
  output logic                  haze_vld_o,
  output logic [DATA_WIDTH-1:0] haze_data_o
);

  localparam int WIN    = 1 << AVG_SHIFT;
  localparam int SUM_W  = DATA_WIDTH + AVG_SHIFT;
  localparam int FILL_W = AVG_SHIFT + 1;

  localparam logic [AVG_SHIFT-1:0] PTR_ONE   = AVG_SHIFT'(1);
  localparam logic [FILL_W-1:0]    FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0]    FILL_MAX  = FILL_W'(WIN);
  localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(WIN - 1);

  // History buffer and stage-1 state
  logic [DATA_WIDTH-1:0] hist_r [WIN];
  logic [AVG_SHIFT-1:0]  wptr_r;
  logic [FILL_W-1:0]     fill_r;
  logic [SUM_W-1:0]      sum_r;
  logic                  s1_r;

  // Combinational helpers
  logic [DATA_WIDTH-1:0] x_s;
  logic [DATA_WIDTH-1:0] old_s;
  logic [SUM_W-1:0]      sum_nxt_s;
  logic [FILL_W-1:0]     fill_nxt_s;
  logic                  s1_nxt_s;

`ifdef HAZE_SAT_EN
  localparam logic [31:0] SAMPLE_MAX = 32'((64'd1 << DATA_WIDTH) - 64'd1);

  // Clamp oversized samples to the largest representable value
  always_comb begin
    x_s = laser_data_i[DATA_WIDTH-1:0];
    if (laser_data_i > SAMPLE_MAX) begin
      x_s = {DATA_WIDTH{1'b1}};
    end else begin
      x_s = laser_data_i[DATA_WIDTH-1:0];
    end
  end
`else
  // Upper sample bits are intentionally discarded in truncation mode
  logic unused_upper_s;
  assign unused_upper_s = ^laser_data_i;

  // Truncate samples to their low DATA_WIDTH bits
  always_comb begin
    x_s = laser_data_i[DATA_WIDTH-1:0];
  end
`endif

  // Next-state arithmetic for the window: the evicted sample leaves the sum
  // as the new one enters, so the sum never exceeds WIN * (2**DATA_WIDTH-1).
  // Until the buffer has filled, evicted entries are the zeros from reset.
  always_comb begin
    old_s     = hist_r[wptr_r];
    sum_nxt_s = sum_r + SUM_W'(x_s) - SUM_W'(old_s);
    if (fill_r == FILL_MAX) begin
      fill_nxt_s = FILL_MAX;
    end else begin
      fill_nxt_s = fill_r + FILL_ONE;
    end
    // This sample completes (or extends) a full window
    s1_nxt_s = (fill_r >= FILL_LAST);
  end

  // Stage 1: accept sample, update buffer, pointer, fill count and running sum
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WIN; i++) begin
        hist_r[i] <= '0;
      end
      wptr_r <= '0;
      fill_r <= '0;
      sum_r  <= '0;
      s1_r   <= 1'b0;
    end else if (laser_vld_i) begin
      hist_r[wptr_r] <= x_s;
      // WIN is a power of two, so the pointer wraps naturally
      wptr_r <= wptr_r + PTR_ONE;
      fill_r <= fill_nxt_s;
      sum_r  <= sum_nxt_s;
      s1_r   <= s1_nxt_s;
    end else begin
      s1_r   <= 1'b0;
    end
  end

  // Stage 2: publish the truncated average one edge after acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      haze_vld_o  <= 1'b0;
      haze_data_o <= '0;
    end else begin
      haze_vld_o <= s1_r;
      if (s1_r) begin
        haze_data_o <= sum_r[SUM_W-1:AVG_SHIFT];
      end else begin
        haze_data_o <= haze_data_o;
      end
    end
  end

endmodule

// File: tb/tb_haze_generate_core.sv
// -----------------------------------------------------------------------------
// tb_haze_generate_core
//
// Self-checking bench for haze_generate_core. A reference model keeps the
// conditioned samples accepted since reset in a queue and computes the
// boxcar average of the newest WIN entries by plain summation and division.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_haze_generate_core;

  localparam int DW  = 16;
  localparam int SH  = 3;
  localparam int WIN = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          laser_vld_i;
  logic [31:0]   laser_data_i;
  logic          haze_vld_o;
  logic [DW-1:0] haze_data_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int hist[$];
  int accepted;
  bit p1_vld;
  int p1_data;
  bit exp_vld;
  int exp_data;

  always #5 clk_i = ~clk_i;

  haze_generate_core #(
    .DATA_WIDTH (DW),
    .AVG_SHIFT  (SH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .laser_vld_i  (laser_vld_i),
    .laser_data_i (laser_data_i),
    .haze_vld_o   (haze_vld_o),
    .haze_data_o  (haze_data_o)
  );

  function automatic int cond(input logic [31:0] d);
    longint v;
    v = longint'(d);
`ifdef HAZE_SAT_EN
    if (v > 65535) return 65535;
    return int'(v);
`else
    return int'(v % 65536);
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    accepted = 0;
    p1_vld   = 1'b0;
    p1_data  = 0;
    exp_vld  = 1'b0;
    exp_data = 0;
  endtask

  // Apply one cycle of stimulus (called at a falling edge) and advance the model
  task automatic drive(input bit v, input logic [31:0] d);
    int s;
    laser_vld_i  = v;
    laser_data_i = d;
    exp_vld = p1_vld;
    if (p1_vld) exp_data = p1_data;
    if (v) begin
      hist.push_back(cond(d));
      if (hist.size() > WIN) void'(hist.pop_front());
      accepted++;
      s = 0;
      foreach (hist[i]) s += hist[i];
      p1_vld  = (accepted >= WIN);
      p1_data = s / WIN;
    end else begin
      p1_vld = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    laser_vld_i  = 1'b0;
    laser_data_i = 32'd0;
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    laser_vld_i  = 1'b0;
    laser_data_i = 32'd0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if (haze_vld_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_vld: got %0b want 0", haze_vld_o);
      end
      checks++;
      if (haze_data_o !== 16'd0) begin
        errors++;
        $display("FAIL reset_data: got %0d want 0", haze_data_o);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_alternate();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      if (i < 16) drive((i % 2) == 0, 32'd5);
      else        drive(1'b0, 32'd0);
      if (haze_vld_o === 1'b1) pulses++;
      checks++;
      if (haze_vld_o !== exp_vld || haze_data_o !== DW'(exp_data)) begin
        errors++;
        $display("FAIL alternate_cycle%0d: got vld=%0b data=%0d want vld=%0b data=%0d",
                 i, haze_vld_o, haze_data_o, exp_vld, exp_data);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL alternate_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (haze_data_o !== 16'd5) begin
      errors++;
      $display("FAIL alternate_data: got %0d want 5", haze_data_o);
    end
  endtask

  task automatic test_ramp();
    int got[$];
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1'b1, 32'(i));
      else        drive(1'b0, 32'd0);
      if (haze_vld_o === 1'b1) got.push_back(int'(haze_data_o));
      checks++;
      if (haze_vld_o !== exp_vld || haze_data_o !== DW'(exp_data)) begin
        errors++;
        $display("FAIL ramp_cycle%0d: got vld=%0b data=%0d want vld=%0b data=%0d",
                 i, haze_vld_o, haze_data_o, exp_vld, exp_data);
      end
    end
    checks++;
    if (got.size() != 9) begin
      errors++;
      $display("FAIL ramp_pulses: got %0d want 9", got.size());
    end else begin
      foreach (got[k]) begin
        checks++;
        if (got[k] != 3 + k) begin
          errors++;
          $display("FAIL ramp_value%0d: got %0d want %0d", k, got[k], 3 + k);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    // Continue from the previous stream so outputs are non-zero when reset hits
    for (int i = 0; i < 5; i++) drive(1'b1, 32'd9);
    laser_vld_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if (haze_vld_o !== 1'b0 || haze_data_o !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got vld=%0b data=%0d want vld=0 data=0", haze_vld_o, haze_data_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if (haze_vld_o !== 1'b0 || haze_data_o !== 16'd0) begin
        errors++;
        $display("FAIL reset_hold%0d: got vld=%0b data=%0d want vld=0 data=0", i, haze_vld_o, haze_data_o);
      end
    end
    rst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 32'd2);
      else       drive(1'b0, 32'd0);
      if (haze_vld_o === 1'b1) pulses++;
      checks++;
      if (haze_vld_o !== exp_vld || haze_data_o !== DW'(exp_data)) begin
        errors++;
        $display("FAIL post_reset_cycle%0d: got vld=%0b data=%0d want vld=%0b data=%0d",
                 i, haze_vld_o, haze_data_o, exp_vld, exp_data);
      end
    end
    checks++;
    if (pulses != 1 || haze_data_o !== 16'd2) begin
      errors++;
      $display("FAIL post_reset_result: got pulses=%0d data=%0d want pulses=1 data=2", pulses, haze_data_o);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] want;
`ifdef HAZE_SAT_EN
    want = 16'hFFFF;
`else
    want = 16'h0000;
`endif
    do_reset();
    // Preload a non-zero window so a truncated result is distinguishable
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, 32'h0001_0000);
      else        drive(1'b0, 32'd0);
      checks++;
      if (haze_vld_o !== exp_vld || haze_data_o !== DW'(exp_data)) begin
        errors++;
        $display("FAIL sat_cycle%0d: got vld=%0b data=%0h want vld=%0b data=%0h",
                 i, haze_vld_o, haze_data_o, exp_vld, exp_data);
      end
    end
    checks++;
    if (haze_data_o !== want) begin
      errors++;
      $display("FAIL sat_data: got %0h want %0h", haze_data_o, want);
    end
  endtask

  task automatic test_random();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      drive((i % 2) == 0, 32'($urandom_range(9, 0)));
      if (haze_vld_o === 1'b1) pulses++;
      checks++;
      if (haze_vld_o !== exp_vld || haze_data_o !== DW'(exp_data)) begin
        errors++;
        $display("FAIL random_cycle%0d: got vld=%0b data=%0d want vld=%0b data=%0d",
                 i, haze_vld_o, haze_data_o, exp_vld, exp_data);
      end
    end
    checks++;
    if (pulses < 400) begin
      errors++;
      $display("FAIL random_pulses: got %0d want at least 400", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1, 0) == 1) d = $urandom;
      else                           d = 32'($urandom_range(65535, 0));
      drive(($urandom_range(7, 0) != 0), d);
      checks++;
      if (haze_vld_o !== exp_vld || haze_data_o !== DW'(exp_data)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got vld=%0b data=%0h want vld=%0b data=%0h",
                 i, haze_vld_o, haze_data_o, exp_vld, exp_data);
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    laser_vld_i  = 1'b0;
    laser_data_i = 32'd0;
    test_reset();
    test_alternate();
    test_ramp();
    test_mid_reset();
    test_saturation();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
